// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, datapath select
// codes, MIPS opcode/func values and ALU operation codes.
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      CL_RALU, CL_IALU, CL_LW, CL_SW, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR, CL_ILLEGAL
   } class_e;

   localparam logic [1:0] PC_PLUS4   = 2'b00;
   localparam logic [1:0] PC_BRANCH  = 2'b01;
   localparam logic [1:0] PC_JUMP    = 2'b10;
   localparam logic [1:0] PC_RS      = 2'b11;

   localparam logic [1:0] DST_RT     = 2'b00;
   localparam logic [1:0] DST_RD     = 2'b01;
   localparam logic [1:0] DST_RA     = 2'b10;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_SHAMT = 2'b10;

   localparam logic [1:0] WB_ALU     = 2'b00;
   localparam logic [1:0] WB_MEM     = 2'b01;
   localparam logic [1:0] WB_PC4     = 2'b10;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0a;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2a;

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_AND  = 5'd2;
   localparam logic [4:0] ALU_OR   = 5'd3;
   localparam logic [4:0] ALU_SLT  = 5'd4;
   localparam logic [4:0] ALU_SLL  = 5'd5;
   localparam logic [4:0] ALU_SRL  = 5'd6;
   localparam logic [4:0] ALU_SRA  = 5'd7;
   localparam logic [4:0] ALU_LUI  = 5'd8;
   localparam logic [4:0] ALU_ADDU = 5'd9;
   localparam logic [4:0] ALU_SUBU = 5'd10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: maps opcode/func to an instruction class,
// ALU operation, operand-B source, immediate extension, destination and legality.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter bit EN_SHIFT = 1'b1
) (
   input  logic [5:0] opcode_i,
   input  logic [5:0] func_i,
   output logic [3:0] instrClass_o,
   output logic [4:0] aluCtrl_o,
   output logic       extOp_o,
   output logic [1:0] aluSrcB_o,
   output logic [1:0] regDst_o,
   output logic       legal_o
);

   class_e cls;

   always_comb begin
      cls       = CL_ILLEGAL;
      aluCtrl_o = ALU_ADD;
      aluSrcB_o = SRCB_REG;
      extOp_o   = 1'b0;
      regDst_o  = DST_RT;
      case (opcode_i)
         OP_RTYPE: begin
            regDst_o = DST_RD;
            case (func_i)
               FN_ADD:  begin cls = CL_RALU; aluCtrl_o = ALU_ADD;  end
               FN_ADDU: begin cls = CL_RALU; aluCtrl_o = ALU_ADDU; end
               FN_SUB:  begin cls = CL_RALU; aluCtrl_o = ALU_SUB;  end
               FN_SUBU: begin cls = CL_RALU; aluCtrl_o = ALU_SUBU; end
               FN_AND:  begin cls = CL_RALU; aluCtrl_o = ALU_AND;  end
               FN_OR:   begin cls = CL_RALU; aluCtrl_o = ALU_OR;   end
               FN_SLT:  begin cls = CL_RALU; aluCtrl_o = ALU_SLT;  end
               FN_JR:   cls = CL_JR;
               // Shifts stay CL_ILLEGAL when the shifter is configured out
               FN_SLL: if (EN_SHIFT) begin cls = CL_RALU; aluCtrl_o = ALU_SLL; aluSrcB_o = SRCB_SHAMT; end
               FN_SRL: if (EN_SHIFT) begin cls = CL_RALU; aluCtrl_o = ALU_SRL; aluSrcB_o = SRCB_SHAMT; end
               FN_SRA: if (EN_SHIFT) begin cls = CL_RALU; aluCtrl_o = ALU_SRA; aluSrcB_o = SRCB_SHAMT; end
               default: ;
            endcase
         end
         OP_ADDI: begin cls = CL_IALU; aluCtrl_o = ALU_ADD; aluSrcB_o = SRCB_IMM; extOp_o = 1'b1; end
         OP_SLTI: begin cls = CL_IALU; aluCtrl_o = ALU_SLT; aluSrcB_o = SRCB_IMM; extOp_o = 1'b1; end
         OP_ORI:  begin cls = CL_IALU; aluCtrl_o = ALU_OR;  aluSrcB_o = SRCB_IMM; end
         OP_LUI:  begin cls = CL_IALU; aluCtrl_o = ALU_LUI; aluSrcB_o = SRCB_IMM; end
         OP_LW:   begin cls = CL_LW;   aluCtrl_o = ALU_ADD; aluSrcB_o = SRCB_IMM; extOp_o = 1'b1; end
         OP_SW:   begin cls = CL_SW;   aluCtrl_o = ALU_ADD; aluSrcB_o = SRCB_IMM; extOp_o = 1'b1; end
         OP_BEQ:  begin cls = CL_BEQ;  aluCtrl_o = ALU_SUB; extOp_o = 1'b1; end
         OP_BNE:  begin cls = CL_BNE;  aluCtrl_o = ALU_SUB; extOp_o = 1'b1; end
         OP_J:    cls = CL_J;
         OP_JAL:  begin cls = CL_JAL;  regDst_o = DST_RA; end
         default: ;
      endcase
   end

   assign instrClass_o = cls;
   assign legal_o      = (cls != CL_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with
// req/ready memory handshakes, a ready-wait timeout and sticky error flags.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W = 5,
   parameter int WAIT_MAX   = 15,
   parameter bit EN_SHIFT   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [5:0]            opcode,
   input  logic [5:0]            func,
   input  logic                  zero,
   input  logic                  imem_ready,
   input  logic                  dmem_ready,
   output logic                  imem_req,
   output logic                  ir_we,
   output logic                  pc_we,
   output logic [1:0]            pc_sel,
   output logic                  reg_we,
   output logic [1:0]            reg_dst,
   output logic [1:0]            alu_src_b,
   output logic                  ext_op,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [1:0]            mem_to_reg,
   output logic                  illegal,
   output logic                  bus_err,
   output logic [2:0]            state_o
);

   localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
   logic             illegal_q, illegal_d;
   logic             busErr_q, busErr_d;

   logic [3:0] decClass;
   logic [4:0] decAlu;
   logic       decExt, decLegal;
   logic [1:0] decSrcB, decDst;
   class_e     instrClass;
   logic       waiting, timedOut;

   ctrl_decode #(.EN_SHIFT(EN_SHIFT)) u_decode (
      .opcode_i     (opcode),
      .func_i       (func),
      .instrClass_o (decClass),
      .aluCtrl_o    (decAlu),
      .extOp_o      (decExt),
      .aluSrcB_o    (decSrcB),
      .regDst_o     (decDst),
      .legal_o      (decLegal)
   );

   assign instrClass = class_e'(decClass);
   assign waiting    = (state_q == ST_FETCH && !imem_ready) || (state_q == ST_MEM && !dmem_ready);
   // Trap on the cycle whose wait would bring the counter up to WAIT_MAX
   assign timedOut   = (WAIT_MAX != 0) && waiting && (waitCnt_q == CNT_W'(WAIT_MAX - 1));

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      busErr_d  = busErr_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_ready) state_d = ST_DECODE;
            else if (timedOut) begin state_d = ST_TRAP; busErr_d = 1'b1; end
         end
         ST_DECODE: begin
            if (decLegal) state_d = ST_EXEC;
            else begin state_d = ST_TRAP; illegal_d = 1'b1; end
         end
         ST_EXEC: begin
            case (instrClass)
               CL_LW, CL_SW:     state_d = ST_MEM;
               CL_RALU, CL_IALU: state_d = ST_WB;
               default:          state_d = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            if (dmem_ready) state_d = (instrClass == CL_LW) ? ST_WB : ST_FETCH;
            else if (timedOut) begin state_d = ST_TRAP; busErr_d = 1'b1; end
         end
         ST_WB:   state_d = ST_FETCH;
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_FETCH;
      endcase
      if (state_d != state_q) waitCnt_d = '0;
      else if (waiting)       waitCnt_d = waitCnt_q + 1'b1;
      else                    waitCnt_d = waitCnt_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_FETCH;
         waitCnt_q <= '0;
         illegal_q <= 1'b0;
         busErr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         illegal_q <= illegal_d;
         busErr_q  <= busErr_d;
      end
   end

   // Enables are gated by rstn so a reset mid-access kills requests/writes at once
   always_comb begin
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = PC_PLUS4;
      reg_we     = 1'b0;
      reg_dst    = DST_RT;
      alu_src_b  = SRCB_REG;
      ext_op     = 1'b0;
      alu_ctrl   = '0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      mem_to_reg = WB_ALU;
      if (state_q != ST_FETCH && state_q != ST_TRAP) begin
         reg_dst    = decDst;
         alu_src_b  = decSrcB;
         ext_op     = decExt;
         alu_ctrl   = ALU_CTRL_W'(decAlu);
         mem_to_reg = (instrClass == CL_LW) ? WB_MEM : (instrClass == CL_JAL) ? WB_PC4 : WB_ALU;
      end
      if (rstn) begin
         case (state_q)
            ST_FETCH: begin
               imem_req = 1'b1;
               ir_we    = imem_ready;
               pc_we    = imem_ready;
            end
            ST_EXEC: begin
               case (instrClass)
                  CL_BEQ: begin pc_we = zero;  pc_sel = PC_BRANCH; end
                  CL_BNE: begin pc_we = ~zero; pc_sel = PC_BRANCH; end
                  CL_J:   begin pc_we = 1'b1;  pc_sel = PC_JUMP;   end
                  CL_JAL: begin pc_we = 1'b1;  pc_sel = PC_JUMP; reg_we = 1'b1; end
                  CL_JR:  begin pc_we = 1'b1;  pc_sel = PC_RS;     end
                  default: ;
               endcase
            end
            ST_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (instrClass == CL_SW);
            end
            ST_WB:   reg_we = 1'b1;
            default: ;
         endcase
      end
   end

   assign illegal = illegal_q;
   assign bus_err = busErr_q;
   assign state_o = state_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle successor to the single-cycle main decoder. An FSM sequences each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB and drives per-state datapath enables. It supports variable-latency instruction and data memories through req/ready handshakes with a timeout. It sits between the IR and the shared multi-cycle datapath (PC, register file, ALU, memories).

Parameters:
ALU_CTRL_W, 5, width of alu_ctrl; values come from the shared ALUOp encodings.
WAIT_MAX, 15, max cycles to wait for any ready; 0 disables the timeout.
EN_SHIFT, 1, 1 = sll/srl/sra legal; 0 = they decode as illegal.

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]; valid from DECODE onward
func  in  6  IR[5:0]
zero  in  1  ALU equality flag from EXEC
imem_ready  in  1  instruction word valid
dmem_ready  in  1  data access complete
imem_req  out  1  instruction fetch request
ir_we  out  1  latch instruction register
pc_we  out  1  PC write enable
pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs (jr)
reg_we  out  1  register file write
reg_dst  out  2  00 rt, 01 rd, 10 $31
alu_src_b  out  2  00 reg, 01 ext imm, 10 shamt
ext_op  out  1  0 zero-extend, 1 sign-extend
alu_ctrl  out  ALU_CTRL_W  ALU operation
dmem_req  out  1  data request
dmem_we  out  1  data write (sw)
mem_to_reg  out  2  00 ALU, 01 mem, 10 PC+4
illegal  out  1  sticky undefined-instruction flag
bus_err  out  1  sticky ready-timeout flag
state_o  out  3  current state, for debug

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Encoding: package constants.
- Reset (rstn=0, asynchronous): state=FETCH, wait counter=0, illegal=0, bus_err=0, all enables/req=0, selects=0.
- Outputs are combinational from the registered state plus opcode/func (Moore-style per state). Only enables and requests are state-gated; in inactive states every enable is 0.
- FETCH: imem_req=1.
  - When imem_ready=1: ir_we=1, pc_we=1, pc_sel=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: classify opcode/func.
  - Undefined opcode, undefined R-type func, or a shift with EN_SHIFT=0: go to TRAP and set illegal.
  - Otherwise go to EXEC.
- EXEC: drive alu_ctrl, alu_src_b and ext_op per instruction.
  - beq: pc_we=zero, pc_sel=01, then FETCH.
  - bne: pc_we=~zero, pc_sel=01, then FETCH.
  - j: pc_we=1, pc_sel=10, then FETCH.
  - jal: pc_we=1, pc_sel=10, reg_we=1, reg_dst=10, mem_to_reg=10, then FETCH.
  - jr: pc_we=1, pc_sel=11, then FETCH.
  - lw/sw: go to MEM.
  - All others: go to WB.
- MEM: dmem_req=1; dmem_we=1 for sw.
  - Hold until dmem_ready.
  - Then sw goes to FETCH; lw goes to WB.
- WB: reg_we=1, then FETCH.
  - R-type: reg_dst=01, mem_to_reg=00.
  - addi/ori/lui/slti: reg_dst=00, mem_to_reg=00.
  - lw: reg_dst=00, mem_to_reg=01.
- Supported instructions and decode:
  - R-type: add, addu, sub, subu, and, or, slt, sll, srl, sra, jr.
  - I/J-type: addi, ori, lui, slti, lw, sw, beq, bne, j, jal.
  - ext_op=1 for addi/slti/lw/sw/beq/bne; 0 otherwise.
- Cycles per instruction at zero wait: branch/jump 3, R-type/ALU-imm/sw 4, lw 5. Each ready wait adds 1 cycle.
- Timeout:
  - The wait counter increments on every FETCH or MEM cycle with ready low, and clears on state change.
  - When the counter reaches WAIT_MAX (if WAIT_MAX>0): go to TRAP, set bus_err, drop the request.
- TRAP: absorbing state with all enables 0. Only rstn exits it.
- Ready asserted in the same cycle the request rises is a legal completion.
- Reset mid-MEM aborts the access immediately; no write occurs after rstn falls.

Decomposition:
- Shared package ctrl_pkg:
  - state encodings;
  - pc_sel, reg_dst, alu_src_b and mem_to_reg codes;
  - opcode/func constants;
  - ALUOp codes.
  These reuse the existing encoding and instruction definition headers.
- One sub-module, ctrl_decode: purely combinational. Maps opcode/func to class, alu_ctrl, ext_op, alu_src_b, reg_dst and legality.
- The FSM and wait counter stay in multicycle_ctrl.

Test Plan:
- Zero-wait addu (opcode 000000, func 100001), readies high:
  - states FETCH,DECODE,EXEC,WB,FETCH;
  - reg_we=1 only in WB, with reg_dst=01;
  - pc_we=1 only in FETCH.
- lw (opcode 100011) with dmem_ready held low 3 cycles:
  - MEM lasts 4 cycles with dmem_req=1 and dmem_we=0;
  - WB has mem_to_reg=01, reg_dst=00.
- beq (opcode 000100):
  - zero=0 gives pc_we=0 in EXEC;
  - repeat with zero=1, giving pc_we=1 and pc_sel=01;
  - bne (opcode 000101) gives the inverse.
- jal (opcode 000011): EXEC has pc_we=1, pc_sel=10, reg_we=1, reg_dst=10, mem_to_reg=10; 3 cycles total.
- Illegal instruction:
  - opcode 111111 gives TRAP after DECODE;
  - illegal=1 persists 20 cycles with all enables 0;
  - rstn pulse clears to FETCH.
- imem_ready stuck 0, WAIT_MAX=15: bus_err=1 and imem_req=0 after 15 wait cycles.
- rstn asserted during MEM of sw: dmem_we drops asynchronously; FETCH after release.
